// File: rtl/hsem_lock_arb_pkg.sv
// Shared configuration for the HSEM lock arbiter: default sizing and FSM state encoding.
// Optional lock-hold timeout is enabled by defining HSEM_LOCK_TIMEOUT_EN.
package hsem_lock_arb_pkg;

    localparam int unsigned HSEM_NUM_MASTER   = 4;
    localparam int unsigned HSEM_ID_WIDTH     = 2;
    localparam int unsigned HSEM_LOCK_TIMEOUT = 1024;
    localparam int unsigned HSEM_TO_WIDTH     = 11;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_LOCKED  = 2'd1,
        ST_RELEASE = 2'd2
    } hsem_state_e;

endpackage

// File: rtl/hsem_lock_arb_if.sv
// Lock request/grant and task-register write-gating signals between the cores and the arbiter.
interface hsem_lock_arb_if #(
    parameter int unsigned NUM_MASTER = 4,
    parameter int unsigned ID_WIDTH   = 2
);

    logic [NUM_MASTER-1:0] req_i;
    logic [NUM_MASTER-1:0] rel_i;
    logic [NUM_MASTER-1:0] wr_req_i;
    logic [NUM_MASTER-1:0] grant_o;
    logic [ID_WIDTH-1:0]   owner_id_o;
    logic                  locked_o;
    logic                  task_en_o;
    logic                  free_o;
    logic                  err_o;
    logic                  timeout_o;

    modport slave (
        input  req_i, rel_i, wr_req_i,
        output grant_o, owner_id_o, locked_o, task_en_o, free_o, err_o, timeout_o
    );

    modport master (
        output req_i, rel_i, wr_req_i,
        input  grant_o, owner_id_o, locked_o, task_en_o, free_o, err_o, timeout_o
    );

endinterface

// File: rtl/hsem_rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping,
// returned as one-hot and binary index.
module hsem_rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = 2
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic [N-1:0]  pick,
    output logic [IW-1:0] pick_idx
);

    logic        found;
    int unsigned cand;

    always_comb begin
        pick     = '0;
        pick_idx = '0;
        found    = 1'b0;
        cand     = 0;
        for (int unsigned i = 0; i < N; i++) begin
            cand = (32'(ptr) + i) % N;
            if (!found && req[IW'(cand)]) begin
                found            = 1'b1;
                pick[IW'(cand)]  = 1'b1;
                pick_idx         = IW'(cand);
            end
        end
    end

endmodule

// File: rtl/hsem_lock_arb.sv
// Round-robin lock arbiter guarding the HSEM task-status register.
// Define HSEM_LOCK_TIMEOUT_EN to force release after TIMEOUT_CYCLES of hold.
module hsem_lock_arb
    import hsem_lock_arb_pkg::*;
#(
    parameter int unsigned NUM_MASTER     = HSEM_NUM_MASTER,
    parameter int unsigned ID_WIDTH       = HSEM_ID_WIDTH,
    parameter int unsigned TIMEOUT_CYCLES = HSEM_LOCK_TIMEOUT,
    parameter int unsigned TO_WIDTH       = HSEM_TO_WIDTH
) (
    input  logic           hclk,
    input  logic           hresetn,
    hsem_lock_arb_if.slave bus
);

    hsem_state_e           state_q, state_nxt;
    logic [NUM_MASTER-1:0] grant_q, grant_nxt;
    logic [ID_WIDTH-1:0]   owner_id_q, owner_nxt;
    logic [ID_WIDTH-1:0]   ptr_q, ptr_nxt;
    logic                  locked_q, locked_nxt;
    logic                  free_q, free_nxt;
    logic                  err_q, err_nxt;
    logic                  timeout_q, timeout_nxt;

    logic [NUM_MASTER-1:0] pick_oh;
    logic [ID_WIDTH-1:0]   pick_idx;
    logic [ID_WIDTH-1:0]   next_ptr;
    logic                  owner_rel;
    logic                  to_hit;

    hsem_rr_pick #(
        .N  (NUM_MASTER),
        .IW (ID_WIDTH)
    ) u_pick (
        .req      (bus.req_i),
        .ptr      (ptr_q),
        .pick     (pick_oh),
        .pick_idx (pick_idx)
    );

    // grant_q is zero outside LOCKED, so any release there is from a non-owner
    assign owner_rel = |(bus.rel_i & grant_q);
    assign next_ptr  = (owner_id_q == ID_WIDTH'(NUM_MASTER - 1)) ? '0 : owner_id_q + ID_WIDTH'(1);

`ifdef HSEM_LOCK_TIMEOUT_EN
    logic [TO_WIDTH-1:0] hold_cnt_q, hold_cnt_nxt;

    // Counter sits at zero outside LOCKED, so it is cleared on every lock entry
    assign hold_cnt_nxt = (state_q == ST_LOCKED) ? hold_cnt_q + TO_WIDTH'(1) : '0;
    assign to_hit       = (state_q == ST_LOCKED) &&
                          (hold_cnt_q == TO_WIDTH'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) hold_cnt_q <= '0;
        else          hold_cnt_q <= hold_cnt_nxt;
    end
`else
    logic unused_cfg;
    assign unused_cfg = ^{TO_WIDTH'(TIMEOUT_CYCLES)};
    assign to_hit     = 1'b0;
`endif

    always_ff @(posedge hclk or negedge hresetn) begin
        if (!hresetn) begin
            state_q    <= ST_IDLE;
            grant_q    <= '0;
            owner_id_q <= '0;
            ptr_q      <= '0;
            locked_q   <= 1'b0;
            free_q     <= 1'b0;
            err_q      <= 1'b0;
            timeout_q  <= 1'b0;
        end else begin
            state_q    <= state_nxt;
            grant_q    <= grant_nxt;
            owner_id_q <= owner_nxt;
            ptr_q      <= ptr_nxt;
            locked_q   <= locked_nxt;
            free_q     <= free_nxt;
            err_q      <= err_nxt;
            timeout_q  <= timeout_nxt;
        end
    end

    always_comb begin
        state_nxt   = state_q;
        grant_nxt   = grant_q;
        owner_nxt   = owner_id_q;
        ptr_nxt     = ptr_q;
        locked_nxt  = locked_q;
        free_nxt    = 1'b0;
        err_nxt     = |(bus.rel_i & ~grant_q);
        timeout_nxt = 1'b0;
        unique case (state_q)
            ST_IDLE: begin
                if (|bus.req_i) begin
                    state_nxt  = ST_LOCKED;
                    grant_nxt  = pick_oh;
                    owner_nxt  = pick_idx;
                    locked_nxt = 1'b1;
                end
            end
            ST_LOCKED: begin
                if (owner_rel || to_hit) begin
                    state_nxt   = ST_RELEASE;
                    grant_nxt   = '0;
                    locked_nxt  = 1'b0;
                    free_nxt    = 1'b1;
                    timeout_nxt = to_hit && !owner_rel;
                    ptr_nxt     = next_ptr;
                end
            end
            ST_RELEASE: begin
                state_nxt = ST_IDLE;
            end
            default: begin
                state_nxt  = ST_IDLE;
                grant_nxt  = '0;
                locked_nxt = 1'b0;
            end
        endcase
    end

    assign bus.grant_o    = grant_q;
    assign bus.owner_id_o = owner_id_q;
    assign bus.locked_o   = locked_q;
    assign bus.free_o     = free_q;
    assign bus.err_o      = err_q;
    assign bus.timeout_o  = timeout_q;
    assign bus.task_en_o  = locked_q & bus.wr_req_i[owner_id_q];

endmodule

// File: tb/tb_hsem_lock_arb.sv
// Directed testbench for hsem_lock_arb: grant latency, round-robin order, write gating,
// illegal releases, hold/timeout behaviour and asynchronous reset.
module tb_hsem_lock_arb;

    logic hclk;
    logic hresetn;
    int   checks;
    int   failures;

    hsem_lock_arb_if #(.NUM_MASTER(4), .ID_WIDTH(2)) bus ();

    hsem_lock_arb #(
        .NUM_MASTER     (4),
        .ID_WIDTH       (2),
        .TIMEOUT_CYCLES (16),
        .TO_WIDTH       (5)
    ) dut (
        .hclk    (hclk),
        .hresetn (hresetn),
        .bus     (bus)
    );

    initial hclk = 1'b0;
    always #5 hclk = ~hclk;

    task automatic tick();
        @(negedge hclk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_lock(input string tag, input logic [3:0] g, input logic [1:0] id,
                            input logic lk);
        chk({tag, ".grant"}, 32'(bus.grant_o), 32'(g));
        if (lk) chk({tag, ".owner"}, 32'(bus.owner_id_o), 32'(id));
        chk({tag, ".locked"}, 32'(bus.locked_o), 32'(lk));
    endtask

    logic [3:0] exp_order [4];

    initial begin
        checks   = 0;
        failures = 0;
        hresetn  = 1'b0;
        bus.req_i    = '0;
        bus.rel_i    = '0;
        bus.wr_req_i = '0;
        exp_order[0] = 4'b0010;
        exp_order[1] = 4'b0100;
        exp_order[2] = 4'b1000;
        exp_order[3] = 4'b0001;

        // reset values
        tick(); tick();
        chk_lock("rst", 4'b0000, 2'd0, 1'b0);
        chk("rst.owner", 32'(bus.owner_id_o), 32'd0);
        chk("rst.free", 32'(bus.free_o), 32'd0);
        chk("rst.err", 32'(bus.err_o), 32'd0);
        chk("rst.timeout", 32'(bus.timeout_o), 32'd0);
        chk("rst.task_en", 32'(bus.task_en_o), 32'd0);
        hresetn = 1'b1;
        tick();

        // single request, one-cycle latency, release pulse
        bus.req_i = 4'b0100;
        tick();
        chk_lock("single", 4'b0100, 2'd2, 1'b1);
        bus.req_i = 4'b0000;
        bus.rel_i = 4'b0100;
        tick();
        chk_lock("single_rel", 4'b0000, 2'd0, 1'b0);
        chk("single_rel.free", 32'(bus.free_o), 32'd1);
        chk("single_rel.err", 32'(bus.err_o), 32'd0);
        bus.rel_i = 4'b0000;
        tick();
        chk("single_idle.free", 32'(bus.free_o), 32'd0);

        // fairness from a fresh pointer
        hresetn = 1'b0;
        tick();
        hresetn = 1'b1;
        tick();
        bus.req_i = 4'b1111;
        tick();
        chk_lock("rr0", 4'b0001, 2'd0, 1'b1);
        for (int k = 0; k < 4; k++) begin
            bus.rel_i = bus.grant_o;
            tick();
            chk("rr.rel_grant", 32'(bus.grant_o), 32'd0);
            chk("rr.rel_free", 32'(bus.free_o), 32'd1);
            bus.rel_i = 4'b0000;
            tick();
            chk("rr.idle_grant", 32'(bus.grant_o), 32'd0);
            tick();
            chk("rr.next_grant", 32'(bus.grant_o), 32'(exp_order[k]));
        end

        // hand over to master 1 for write gating
        bus.rel_i = 4'b0001;
        tick();
        bus.rel_i = 4'b0000;
        tick(); tick();
        chk_lock("wr_owner", 4'b0010, 2'd1, 1'b1);
        bus.wr_req_i = 4'b0011;
        #1;
        chk("wr.owner_write", 32'(bus.task_en_o), 32'd1);
        bus.wr_req_i = 4'b0001;
        #1;
        chk("wr.nonowner_write", 32'(bus.task_en_o), 32'd0);
        bus.wr_req_i = 4'b0000;

        // advance to owner 3
        for (int k = 0; k < 2; k++) begin
            bus.rel_i = bus.grant_o;
            tick();
            bus.rel_i = 4'b0000;
            tick(); tick();
        end
        chk_lock("ill_owner", 4'b1000, 2'd3, 1'b1);

        // non-owner release while locked
        bus.rel_i = 4'b0001;
        tick();
        chk("ill.err", 32'(bus.err_o), 32'd1);
        chk_lock("ill.kept", 4'b1000, 2'd3, 1'b1);
        chk("ill.free", 32'(bus.free_o), 32'd0);
        bus.rel_i = 4'b0000;
        tick();
        chk("ill.err_clear", 32'(bus.err_o), 32'd0);

        // owner and non-owner release together
        bus.rel_i = 4'b1001;
        tick();
        chk("both.free", 32'(bus.free_o), 32'd1);
        chk("both.err", 32'(bus.err_o), 32'd1);
        chk("both.locked", 32'(bus.locked_o), 32'd0);
        bus.rel_i = 4'b0000;
        bus.req_i = 4'b0000;
        tick();
        chk("both.err_clear", 32'(bus.err_o), 32'd0);

        // release while idle
        bus.rel_i = 4'b0010;
        tick();
        chk("idle_rel.err", 32'(bus.err_o), 32'd1);
        chk("idle_rel.free", 32'(bus.free_o), 32'd0);
        chk("idle_rel.locked", 32'(bus.locked_o), 32'd0);
        bus.rel_i = 4'b0000;
        tick();

        // hold: pointer wrapped to 0, master 0 takes the lock and never releases
        bus.req_i = 4'b0001;
        tick();
        chk_lock("hold", 4'b0001, 2'd0, 1'b1);
        bus.req_i = 4'b0000;
`ifdef HSEM_LOCK_TIMEOUT_EN
        repeat (15) tick();
        chk_lock("to.before", 4'b0001, 2'd0, 1'b1);
        chk("to.before_timeout", 32'(bus.timeout_o), 32'd0);
        tick();
        chk("to.timeout", 32'(bus.timeout_o), 32'd1);
        chk("to.free", 32'(bus.free_o), 32'd1);
        chk("to.grant", 32'(bus.grant_o), 32'd0);
        bus.req_i = 4'b1111;
        tick();
        chk("to.timeout_clear", 32'(bus.timeout_o), 32'd0);
        tick();
        chk_lock("to.next", 4'b0010, 2'd1, 1'b1);
`else
        repeat (2000) tick();
        chk_lock("hold.2000", 4'b0001, 2'd0, 1'b1);
        chk("hold.timeout", 32'(bus.timeout_o), 32'd0);
        chk("hold.free", 32'(bus.free_o), 32'd0);
`endif

        // reset while master 2 owns the lock
        hresetn = 1'b0;
        tick();
        hresetn = 1'b1;
        bus.req_i = 4'b0100;
        tick();
        chk_lock("mid.owner", 4'b0100, 2'd2, 1'b1);
        bus.wr_req_i = 4'b0100;
        hresetn = 1'b0;
        #1;
        chk_lock("mid.rst", 4'b0000, 2'd0, 1'b0);
        chk("mid.rst_owner", 32'(bus.owner_id_o), 32'd0);
        chk("mid.rst_task_en", 32'(bus.task_en_o), 32'd0);
        chk("mid.rst_free", 32'(bus.free_o), 32'd0);
        bus.wr_req_i = 4'b0000;
        tick();
        hresetn = 1'b1;
        bus.req_i = 4'b1111;
        tick();
        chk_lock("mid.after", 4'b0001, 2'd0, 1'b1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
